jtag_shift_engine: RTL

VME-driven JTAG shift engine for the DMB7 VME FPGA. It sits downstream of the VME address decoder and DTACK logic. It turns single-cycle VME command strobes into TCK/TMS/TDI sequences on one selected JTAG chain (e.g. the CFEB chain), and captures TDO into a readback register. It returns a one-cycle ACK that the decoder uses to assert ODTACK_B.

---
 rtl/jtag_shift_engine.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_shift_engine.sv
// -----------------------------------------------------------------------------
// jtag_shift_engine
//
// Converts single-cycle VME command strobes into TCK/TMS/TDI sequences on the
// selected JTAG chain, captures TDO into a 16-bit readback register and returns
// a one-cycle ACK for the DTACK logic.
//
// Address decode (CMD_ADR carries VME address bits [11:2]):
//   CMD_ADR[9:6] = NB-1 (1..16 shift bits), CMD_ADR[5:0] = function code F.
//   Write F=0x00..0x07 : shift (F[0] header, F[1] trailer, F[2] IR/DR)
//   Write F=0x06       : JTAG reset (TMS 1,1,1,1,1,0)
//   Write F=0x08       : SEL <= DIN
//   Read  F=0x05       : DOUT = TDO register
//   Read  F=0x09       : DOUT = SEL (zero-extended)
//
// Ports:
//   FPGACLK  system clock          RST_B  async active-low reset
//   CMD_STB  command strobe        CMD_WR 1=write 0=read
//   CMD_ADR  address [11:2]        DIN    write data
//   DOUT     read data (with ACK)  ACK    command-complete pulse
//   BUSY     sequence running      ERR    command-rejected pulse
//   TCK/TMS/TDI JTAG drive         TDO    JTAG return
//   SEL      chain-select register
// -----------------------------------------------------------------------------
module jtag_shift_engine #(
  parameter int TCK_DIV = 2,
  parameter int SEL_W   = 7
) (
  input  logic             FPGACLK,
  input  logic             RST_B,
  input  logic             CMD_STB,
  input  logic             CMD_WR,
  input  logic [9:0]       CMD_ADR,
  input  logic [15:0]      DIN,
  output logic [15:0]      DOUT,
  output logic             ACK,
  output logic             BUSY,
  output logic             ERR,
  output logic             TCK,
  output logic             TMS,
  output logic             TDI,
  input  logic             TDO,
  output logic [SEL_W-1:0] SEL
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

  localparam logic [5:0] F_TDO_RD = 6'h05;
  localparam logic [5:0] F_RESET  = 6'h06;
  localparam logic [5:0] F_SEL_WR = 6'h08;
  localparam logic [5:0] F_SEL_RD = 6'h09;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SHIFT,
    S_TRL,
    S_RST,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;      // TCK index within the current state
  logic [DIV_W-1:0]      r_div;      // FPGACLK count within a TCK half-period
  logic                  r_high;     // 1 while in the TCK-high half
  logic                  r_ir;
  logic                  r_trl;
  logic [3:0]            r_nb_m1;
  logic [15:0]           r_data;
  logic [15:0]           r_tdo_reg;
  logic [15:0]           r_dout;
  logic                  r_ack;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_tck;
  logic                  r_tms;
  logic                  r_tdi;
  logic [SEL_W-1:0]      r_sel;

  logic [5:0]            w_fn;
  logic [3:0]            w_nb_m1;
  logic                  w_is_shift;
  state_t                w_lstate;
  logic                  w_ltms;
  logic                  w_ltdi;
  logic                  w_last;
  state_t                w_nstate;
  logic [3:0]            w_ncnt;
  logic                  w_ntms;
  logic                  w_ntdi;

  // TMS value for TCK number cnt of a given state.
  function automatic logic tms_for(input state_t st, input logic [3:0] cnt,
                                   input logic ir, input logic trl,
                                   input logic [3:0] nb_m1);
    case (st)
      S_HDR:   tms_for = ir ? (cnt < 4'd2) : (cnt == 4'd0);
      S_SHIFT: tms_for = trl && (cnt == nb_m1);  // exit to Exit1 on last bit
      S_TRL:   tms_for = (cnt == 4'd0);
      S_RST:   tms_for = (cnt < 4'd5);
      default: tms_for = 1'b0;
    endcase
  endfunction

  // TDI only carries data during SHIFT, LSB first.
  function automatic logic tdi_for(input state_t st, input logic [3:0] cnt,
                                   input logic [15:0] data);
    tdi_for = (st == S_SHIFT) ? data[cnt] : 1'b0;
  endfunction

  function automatic logic [3:0] last_cnt(input state_t st, input logic ir,
                                          input logic [3:0] nb_m1);
    case (st)
      S_HDR:   last_cnt = ir ? 4'd3 : 4'd2;
      S_SHIFT: last_cnt = nb_m1;
      S_TRL:   last_cnt = 4'd1;
      S_RST:   last_cnt = 4'd5;
      default: last_cnt = 4'd0;
    endcase
  endfunction

  assign w_fn       = CMD_ADR[5:0];
  assign w_nb_m1    = CMD_ADR[9:6];
  assign w_is_shift = CMD_WR && (w_fn[5:3] == 3'b000);

  // First TCK of a newly launched sequence.
  always_comb begin
    w_lstate = S_SHIFT;
    if (w_fn == F_RESET)
      w_lstate = S_RST;
    else if (w_fn[0])
      w_lstate = S_HDR;
    w_ltms = tms_for(w_lstate, 4'd0, w_fn[2], w_fn[1], w_nb_m1);
    w_ltdi = tdi_for(w_lstate, 4'd0, DIN);
  end

  // Next TCK once the current one finishes its high half.
  always_comb begin
    w_last   = (r_cnt == last_cnt(r_state, r_ir, r_nb_m1));
    w_nstate = r_state;
    w_ncnt   = r_cnt + 4'd1;
    if (w_last) begin
      w_ncnt = 4'd0;
      case (r_state)
        S_HDR:   w_nstate = S_SHIFT;
        S_SHIFT: w_nstate = r_trl ? S_TRL : S_DONE;
        default: w_nstate = S_DONE;
      endcase
    end
    w_ntms = tms_for(w_nstate, w_ncnt, r_ir, r_trl, r_nb_m1);
    w_ntdi = tdi_for(w_nstate, w_ncnt, r_data);
  end

  always_ff @(posedge FPGACLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_high    <= 1'b0;
      r_ir      <= 1'b0;
      r_trl     <= 1'b0;
      r_nb_m1   <= '0;
      r_data    <= '0;
      r_tdo_reg <= '0;
      r_dout    <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_tck     <= 1'b0;
      r_tms     <= 1'b0;
      r_tdi     <= 1'b0;
      r_sel     <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        // The ACK cycle (DONE) accepts commands just like IDLE.
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (CMD_STB) begin
            if (w_is_shift) begin
              r_state <= w_lstate;
              r_cnt   <= 4'd0;
              r_div   <= '0;
              r_high  <= 1'b0;
              r_ir    <= w_fn[2];
              r_trl   <= w_fn[1];
              r_nb_m1 <= w_nb_m1;
              r_data  <= DIN;
              r_busy  <= 1'b1;
              r_tck   <= 1'b0;
              r_tms   <= w_ltms;
              r_tdi   <= w_ltdi;
            end else begin
              r_ack  <= 1'b1;
              r_dout <= '0;
              if (CMD_WR && (w_fn == F_SEL_WR))
                r_sel <= DIN[SEL_W-1:0];
              if (!CMD_WR && (w_fn == F_TDO_RD))
                r_dout <= r_tdo_reg;
              if (!CMD_WR && (w_fn == F_SEL_RD))
                r_dout <= 16'(r_sel);
            end
          end
        end
        default: begin
          // Any strobe during a sequence is dropped and flagged.
          if (CMD_STB)
            r_err <= 1'b1;
          if (r_div != DIV_LAST) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_high) begin
              r_high <= 1'b1;
              r_tck  <= 1'b1;
              if (r_state == S_SHIFT)
                r_tdo_reg <= {TDO, r_tdo_reg[15:1]};
            end else begin
              r_high  <= 1'b0;
              r_tck   <= 1'b0;
              r_state <= w_nstate;
              r_cnt   <= w_ncnt;
              if (w_nstate == S_DONE) begin
                // TMS/TDI keep their last values until the next sequence.
                r_busy <= 1'b0;
                r_ack  <= 1'b1;
                r_dout <= '0;
              end else begin
                r_tms <= w_ntms;
                r_tdi <= w_ntdi;
              end
            end
          end
        end
      endcase
    end
  end

  assign DOUT = r_dout;
  assign ACK  = r_ack;
  assign BUSY = r_busy;
  assign ERR  = r_err;
  assign TCK  = r_tck;
  assign TMS  = r_tms;
  assign TDI  = r_tdi;
  assign SEL  = r_sel;

endmodule
